// File: rtl/axis_impulse_src.sv
`default_nettype none
// ============================================================================
// Module   : axis_impulse_src
// Brief    : AXI-Stream master emitting SAMP complex samples with one real
//            impulse per PERIOD. Frames are tlast-delimited every TLAST_LEN
//            beats, with a short final frame allowed. A sticky done flag is
//            raised once the last beat has been accepted.
// Revision : 1.0 - initial release
// ============================================================================
module axis_impulse_src #(
    parameter int WIDTH         = 16,
    parameter int PERIOD        = 64,
    parameter int IMPULSE_PHASE = 9,
    parameter int PULSE_VAL     = 64,
    parameter int SAMP          = 2048,
    parameter int TLAST_LEN     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    output logic [2*WIDTH-1:0]         m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       done,
    output logic [$clog2(SAMP+1)-1:0]  beat_count
);

    localparam int CW = $clog2(SAMP + 1);
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int FW = (TLAST_LEN > 1) ? $clog2(TLAST_LEN) : 1;

    localparam logic [PW-1:0]    c_PHASE_LAST = PW'(PERIOD - 1);
    localparam logic [PW-1:0]    c_IMP_PHASE  = PW'(IMPULSE_PHASE);
    localparam logic [FW-1:0]    c_FRAME_LAST = FW'(TLAST_LEN - 1);
    localparam logic [CW-1:0]    c_SAMP_LAST  = CW'(SAMP - 1);
    localparam logic [WIDTH-1:0] c_PULSE      = WIDTH'(PULSE_VAL);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Registered state. phase/frame/count always describe the beat that is
    // currently presented, or the next one to present while paused.
    logic [1:0]         state_q,  state_d;
    logic               tvalid_q, tvalid_d;
    logic [2*WIDTH-1:0] tdata_q,  tdata_d;
    logic               tlast_q,  tlast_d;
    logic               done_q,   done_d;
    logic [CW-1:0]      count_q,  count_d;
    logic [PW-1:0]      phase_q,  phase_d;
    logic [FW-1:0]      frame_q,  frame_d;

    logic               w_xfer;
    logic [PW-1:0]      w_phase_inc;
    logic [FW-1:0]      w_frame_inc;
    logic [CW-1:0]      w_count_inc;
    logic [PW-1:0]      w_sel_phase;
    logic [FW-1:0]      w_sel_frame;
    logic [CW-1:0]      w_sel_count;
    logic [WIDTH-1:0]   w_sel_real;
    logic               w_sel_tlast;

    assign w_xfer      = tvalid_q & m_axis_tready;
    assign w_phase_inc = (phase_q == c_PHASE_LAST) ? '0 : phase_q + 1'b1;
    assign w_frame_inc = (frame_q == c_FRAME_LAST) ? '0 : frame_q + 1'b1;
    assign w_count_inc = count_q + 1'b1;

    // The beat to load: after a transfer it is the following beat, otherwise
    // (start from idle or resume from pause) it is the one the counters hold.
    assign w_sel_phase = w_xfer ? w_phase_inc : phase_q;
    assign w_sel_frame = w_xfer ? w_frame_inc : frame_q;
    assign w_sel_count = w_xfer ? w_count_inc : count_q;
    assign w_sel_real  = (w_sel_phase == c_IMP_PHASE) ? c_PULSE : '0;
    assign w_sel_tlast = (w_sel_frame == c_FRAME_LAST) || (w_sel_count == c_SAMP_LAST);

    // Next-state logic for the IDLE/RUN/DONE sequencer and the output beat.
    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        done_d   = done_q;
        count_d  = count_q;
        phase_d  = phase_q;
        frame_d  = frame_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d  = S_RUN;
                    tvalid_d = 1'b1;
                    tdata_d  = {{WIDTH{1'b0}}, w_sel_real};
                    tlast_d  = w_sel_tlast;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    count_d = w_count_inc;
                    phase_d = w_phase_inc;
                    frame_d = w_frame_inc;
                    if (count_q == c_SAMP_LAST) begin
                        state_d  = S_DONE;
                        tvalid_d = 1'b0;
                        tdata_d  = '0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                    end else if (en) begin
                        tvalid_d = 1'b1;
                        tdata_d  = {{WIDTH{1'b0}}, w_sel_real};
                        tlast_d  = w_sel_tlast;
                    end else begin
                        tvalid_d = 1'b0;
                    end
                end else if (!tvalid_q && en) begin
                    // Resume after a pause; a presented beat is never retracted.
                    tvalid_d = 1'b1;
                    tdata_d  = {{WIDTH{1'b0}}, w_sel_real};
                    tlast_d  = w_sel_tlast;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            phase_q  <= '0;
            frame_q  <= '0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
            frame_q  <= frame_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign done          = done_q;
    assign beat_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_impulse_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_impulse_src
// Brief    : Scoreboard bench for axis_impulse_src. Three instances cover the
//            default configuration, a short run and a negative pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_impulse_src;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        tready;
    int          sel;

    logic        en_main, en_short, en_neg;
    logic        rdy_main, rdy_short, rdy_neg;
    logic [31:0] td_main, td_short, td_neg;
    logic        tv_main, tv_short, tv_neg;
    logic        tl_main, tl_short, tl_neg;
    logic        dn_main, dn_short, dn_neg;
    logic [11:0] bc_main;
    logic [6:0]  bc_short;
    logic [5:0]  bc_neg;

    logic [31:0] mon_td;
    logic        mon_tv, mon_tl, mon_dn;
    logic [11:0] mon_bc;

    logic [32:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign en_main   = en && (sel == 0);
    assign en_short  = en && (sel == 1);
    assign en_neg    = en && (sel == 2);
    assign rdy_main  = tready && (sel == 0);
    assign rdy_short = tready && (sel == 1);
    assign rdy_neg   = tready && (sel == 2);

    axis_impulse_src u_main (
        .clk(clk), .rst_n(rst_n), .en(en_main),
        .m_axis_tdata(td_main), .m_axis_tvalid(tv_main), .m_axis_tready(rdy_main),
        .m_axis_tlast(tl_main), .done(dn_main), .beat_count(bc_main)
    );

    axis_impulse_src #(.SAMP(100), .TLAST_LEN(64)) u_short (
        .clk(clk), .rst_n(rst_n), .en(en_short),
        .m_axis_tdata(td_short), .m_axis_tvalid(tv_short), .m_axis_tready(rdy_short),
        .m_axis_tlast(tl_short), .done(dn_short), .beat_count(bc_short)
    );

    axis_impulse_src #(.PULSE_VAL(-1), .IMPULSE_PHASE(0), .PERIOD(8),
                       .SAMP(40), .TLAST_LEN(16)) u_neg (
        .clk(clk), .rst_n(rst_n), .en(en_neg),
        .m_axis_tdata(td_neg), .m_axis_tvalid(tv_neg), .m_axis_tready(rdy_neg),
        .m_axis_tlast(tl_neg), .done(dn_neg), .beat_count(bc_neg)
    );

    always_comb begin
        mon_td = td_main; mon_tv = tv_main; mon_tl = tl_main;
        mon_dn = dn_main; mon_bc = bc_main;
        if (sel == 1) begin
            mon_td = td_short; mon_tv = tv_short; mon_tl = tl_short;
            mon_dn = dn_short; mon_bc = {5'd0, bc_short};
        end else if (sel == 2) begin
            mon_td = td_neg; mon_tv = tv_neg; mon_tl = tl_neg;
            mon_dn = dn_neg; mon_bc = {6'd0, bc_neg};
        end
    end

    // Reference model of beat i: {tlast, imag, real}.
    function automatic logic [32:0] exp_beat(input int i, input int per, input int ph,
                                             input int pv, input int tl, input int sm);
        logic [15:0] re;
        logic        lst;
        re  = ((i % per) == ph) ? 16'(pv) : 16'h0000;
        lst = ((i % tl) == (tl - 1)) || (i == (sm - 1));
        return {lst, 16'h0000, re};
    endfunction

    task automatic push_all(input int per, input int ph, input int pv, input int tl, input int sm);
        for (int i = 0; i < sm; i++) sb.push_back(exp_beat(i, per, ph, pv, tl, sm));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; en = 1'b0; tready = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        @(negedge clk);
        n_vec++; if (mon_tv !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", mon_tv); end
        n_vec++; if (mon_td !== 32'h0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", mon_td); end
        n_vec++; if (mon_tl !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", mon_tl); end
        n_vec++; if (mon_dn !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", mon_dn); end
        n_vec++; if (mon_bc !== 12'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", mon_bc); end
        @(posedge clk); #1;
    endtask

    task automatic test_const_ready();
        int nx = 0;
        sel = 0;
        do_reset();
        push_all(64, 9, 64, 64, 2048);
        en = 1'b1; tready = 1'b1;
        @(negedge clk);
        n_vec++; if (mon_tv !== 1'b0) begin n_err++; $display("FAIL const_latency0: tvalid %b want 0", mon_tv); end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if (mon_tv !== 1'b1) begin n_err++; $display("FAIL const_latency1: tvalid %b want 1", mon_tv); end
        for (int cyc = 0; cyc < 5000 && nx < 2048; cyc++) begin
            if (mon_tv && tready) begin
                n_vec++;
                if (sb.size() == 0) begin n_err++; $display("FAIL const_extra: beat %0d beyond expected", nx); end
                else if ({mon_tl, mon_td} !== sb[0]) begin
                    n_err++; $display("FAIL const_beat %0d: got %h want %h", nx, {mon_tl, mon_td}, sb[0]);
                end
                if (sb.size() != 0) void'(sb.pop_front());
                nx++;
            end
            @(posedge clk); #1;
            @(negedge clk);
        end
        n_vec++; if (nx != 2048) begin n_err++; $display("FAIL const_count: transfers %0d want 2048", nx); end
        n_vec++; if (mon_dn !== 1'b1) begin n_err++; $display("FAIL const_done: got %b want 1", mon_dn); end
        n_vec++; if (mon_tv !== 1'b0) begin n_err++; $display("FAIL const_tvalid_end: got %b want 0", mon_tv); end
        n_vec++; if (mon_bc !== 12'd2048) begin n_err++; $display("FAIL const_beatcount: got %0d want 2048", mon_bc); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_ready(input int which, input int per, input int ph, input int pv,
                                     input int tl, input int sm);
        int nx = 0;
        logic pv_v = 1'b0, pv_r = 1'b0;
        logic [32:0] pv_d = '0;
        sel = which;
        do_reset();
        push_all(per, ph, pv, tl, sm);
        en = 1'b1; tready = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 20000 && nx < sm; cyc++) begin
            if (pv_v && !pv_r) begin
                n_vec++;
                if (mon_tv !== 1'b1 || {mon_tl, mon_td} !== pv_d) begin
                    n_err++; $display("FAIL rand_stall_stable beat %0d: got v=%b %h want v=1 %h", nx, mon_tv, {mon_tl, mon_td}, pv_d);
                end
            end
            if (mon_tv && tready) begin
                n_vec++;
                if (sb.size() == 0) begin n_err++; $display("FAIL rand_extra: beat %0d beyond expected", nx); end
                else if ({mon_tl, mon_td} !== sb[0]) begin
                    n_err++; $display("FAIL rand_beat %0d: got %h want %h", nx, {mon_tl, mon_td}, sb[0]);
                end
                if (sb.size() != 0) void'(sb.pop_front());
                nx++;
            end
            pv_v = mon_tv; pv_r = tready; pv_d = {mon_tl, mon_td};
            @(posedge clk); #1;
            tready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        n_vec++; if (nx != sm) begin n_err++; $display("FAIL rand_count: transfers %0d want %0d", nx, sm); end
        n_vec++; if (mon_dn !== 1'b1) begin n_err++; $display("FAIL rand_done: got %b want 1", mon_dn); end
        n_vec++; if (mon_bc !== 12'(sm)) begin n_err++; $display("FAIL rand_beatcount: got %0d want %0d", mon_bc, sm); end
        @(posedge clk); #1;
    endtask

    task automatic test_pause();
        int nx = 0;
        int pk = 0;
        int k_chk = -1;
        sel = 0;
        do_reset();
        push_all(64, 9, 64, 64, 2048);
        en = 1'b1; tready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 5000 && nx < 2048; cyc++) begin
            if (k_chk >= 0 && k_chk <= 2) begin
                n_vec++;
                if (mon_tv !== 1'b1 || sb.size() == 0 || {mon_tl, mon_td} !== sb[0] || mon_bc !== 12'd100) begin
                    n_err++; $display("FAIL pause_hold k=%0d: got v=%b %h cnt=%0d want v=1 beat100 cnt=100", k_chk, mon_tv, {mon_tl, mon_td}, mon_bc);
                end
            end
            if (k_chk >= 4) begin
                n_vec++;
                if (mon_tv !== 1'b0 || mon_bc !== 12'd101) begin
                    n_err++; $display("FAIL pause_idle k=%0d: got v=%b cnt=%0d want v=0 cnt=101", k_chk, mon_tv, mon_bc);
                end
            end
            if (mon_tv && tready) begin
                n_vec++;
                if (sb.size() == 0) begin n_err++; $display("FAIL pause_extra: beat %0d beyond expected", nx); end
                else if ({mon_tl, mon_td} !== sb[0]) begin
                    n_err++; $display("FAIL pause_beat %0d: got %h want %h", nx, {mon_tl, mon_td}, sb[0]);
                end
                if (sb.size() != 0) void'(sb.pop_front());
                nx++;
            end
            @(posedge clk); #1;
            if (nx >= 100 && pk < 10) begin
                k_chk = pk; en = 1'b0; tready = (pk >= 3); pk++;
            end else begin
                k_chk = -1; en = 1'b1; tready = 1'b1;
            end
            @(negedge clk);
        end
        n_vec++; if (nx != 2048) begin n_err++; $display("FAIL pause_count: transfers %0d want 2048", nx); end
        n_vec++; if (mon_dn !== 1'b1 || mon_bc !== 12'd2048) begin
            n_err++; $display("FAIL pause_done: done=%b cnt=%0d want 1/2048", mon_dn, mon_bc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_midrun_reset();
        int nx = 0;
        sel = 0;
        do_reset();
        push_all(64, 9, 64, 64, 2048);
        en = 1'b1; tready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 2000 && mon_bc != 12'd500; cyc++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        n_vec++; if (mon_tv !== 1'b1 || mon_bc !== 12'd500) begin
            n_err++; $display("FAIL mreset_reach: v=%b cnt=%0d want 1/500", mon_tv, mon_bc);
        end
        @(posedge clk); #1;
        rst_n = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if ({mon_tv, mon_tl, mon_dn, mon_td, mon_bc} !== 47'd0) begin
            n_err++; $display("FAIL mreset_outputs: v=%b l=%b d=%b data=%h cnt=%0d want all 0", mon_tv, mon_tl, mon_dn, mon_td, mon_bc);
        end
        n_vec++; if (u_main.state_q !== 2'd0) begin n_err++; $display("FAIL mreset_state: got %0d want 0 (IDLE)", u_main.state_q); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        push_all(64, 9, 64, 64, 2048);
        en = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 200 && nx < 20; cyc++) begin
            if (mon_tv && tready) begin
                n_vec++;
                if ({mon_tl, mon_td} !== sb[0]) begin
                    n_err++; $display("FAIL mreset_beat %0d: got %h want %h", nx, {mon_tl, mon_td}, sb[0]);
                end
                void'(sb.pop_front());
                nx++;
            end
            @(posedge clk); #1;
            @(negedge clk);
        end
        n_vec++; if (nx != 20) begin n_err++; $display("FAIL mreset_restart: transfers %0d want 20", nx); end
        @(posedge clk); #1;
    endtask

    task automatic test_short_done();
        int nx = 0;
        sel = 1;
        do_reset();
        push_all(64, 9, 64, 64, 100);
        en = 1'b1; tready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 500 && nx < 100; cyc++) begin
            if (mon_tv && tready) begin
                n_vec++;
                if (sb.size() == 0) begin n_err++; $display("FAIL short_extra: beat %0d beyond expected", nx); end
                else if ({mon_tl, mon_td} !== sb[0]) begin
                    n_err++; $display("FAIL short_beat %0d: got %h want %h", nx, {mon_tl, mon_td}, sb[0]);
                end
                if (sb.size() != 0) void'(sb.pop_front());
                nx++;
            end
            @(posedge clk); #1;
            @(negedge clk);
        end
        n_vec++; if (nx != 100) begin n_err++; $display("FAIL short_count: transfers %0d want 100", nx); end
        n_vec++; if (mon_dn !== 1'b1 || mon_bc !== 12'd100) begin
            n_err++; $display("FAIL short_done: done=%b cnt=%0d want 1/100", mon_dn, mon_bc);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            en = (i % 2) == 0;
            @(negedge clk);
            n_vec++;
            if (mon_tv !== 1'b0 || mon_dn !== 1'b1) begin
                n_err++; $display("FAIL short_absorb %0d: v=%b done=%b want 0/1", i, mon_tv, mon_dn);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; tready = 1'b0; sel = 0;
        test_reset();
        test_const_ready();
        test_random_ready(0, 64, 9, 64, 64, 2048);
        test_pause();
        test_midrun_reset();
        test_short_done();
        test_random_ready(2, 8, 0, -1, 16, 40);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
